// File: rtl/vga_timing_pkg.sv
// Shared video mode definitions and timing helpers for vga_timing_gen.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        h_pol;
    logic        v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
    h_pol: 1'b0, v_pol: 1'b0};

  localparam vga_mode_t MODE_640x480_72 = '{
    h_active: 16'd640, h_fp: 16'd24, h_sync: 16'd40,  h_bp: 16'd128,
    v_active: 16'd480, v_fp: 16'd9,  v_sync: 16'd3,   v_bp: 16'd28,
    h_pol: 1'b0, v_pol: 1'b0};

  localparam vga_mode_t MODE_800x600_72 = '{
    h_active: 16'd800, h_fp: 16'd56, h_sync: 16'd120, h_bp: 16'd64,
    v_active: 16'd600, v_fp: 16'd37, v_sync: 16'd6,   v_bp: 16'd23,
    h_pol: 1'b1, v_pol: 1'b1};

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter 0..LAST with combinational terminal-count flag.
module vga_axis_counter #(
  parameter int W    = 10,
  parameter int LAST = 831
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST_C = W'(LAST);

  assign tc = (count == LAST_C);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing generator with registered sync/de/coords/strobes.
// Optional pixel clock-enable port px_ce when VGA_TIMING_CE_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = int'(MODE_640x480_72.h_active),
  parameter int   H_FP     = int'(MODE_640x480_72.h_fp),
  parameter int   H_SYNC   = int'(MODE_640x480_72.h_sync),
  parameter int   H_BP     = int'(MODE_640x480_72.h_bp),
  parameter int   V_ACTIVE = int'(MODE_640x480_72.v_active),
  parameter int   V_FP     = int'(MODE_640x480_72.v_fp),
  parameter int   V_SYNC   = int'(MODE_640x480_72.v_sync),
  parameter int   V_BP     = int'(MODE_640x480_72.v_bp),
  parameter logic H_POL    = MODE_640x480_72.h_pol,
  parameter logic V_POL    = MODE_640x480_72.v_pol,
  parameter int   COORD_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
`ifdef VGA_TIMING_CE_EN
  input  logic               px_ce,
`endif
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [15:0]        frame_count
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 ||
      V_BP == 0 || longint'(H_TOTAL) > (64'd1 << COORD_W) ||
      longint'(V_TOTAL) > (64'd1 << COORD_W)) begin : g_bad_params
    $error("vga_timing_gen: zero porch/sync or COORD_W too narrow");
  end

  localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               ce;
  logic [COORD_W-1:0] h, v;
  logic               h_tc, v_tc;
  logic               frame_done;

`ifdef VGA_TIMING_CE_EN
  assign ce = px_ce;
`else
  assign ce = 1'b1;
`endif

  vga_axis_counter #(.W(COORD_W), .LAST(H_TOTAL - 1)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ce),
    .count (h),
    .tc    (h_tc)
  );

  vga_axis_counter #(.W(COORD_W), .LAST(V_TOTAL - 1)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ce && h_tc),
    .count (v),
    .tc    (v_tc)
  );

  // frame_done marks a completed frame so the frame_start after reset is not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done   <= 1'b0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      de           <= 1'b0;
      x            <= '0;
      y            <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else if (ce) begin
      frame_done   <= h_tc && v_tc;
      hsync        <= (h >= HS_BEG && h < HS_END) ? H_POL : ~H_POL;
      vsync        <= (v >= VS_BEG && v < VS_END) ? V_POL : ~V_POL;
      de           <= (h < H_ACT_C) && (v < V_ACT_C);
      x            <= h;
      y            <= v;
      line_start   <= (h == '0);
      frame_start  <= (h == '0) && (v == '0);
      vblank_start <= (h == '0) && (v == V_ACT_C);
      if ((h == '0) && (v == '0))
        frame_count <= frame_count + {15'd0, frame_done};
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced video mode (25x17 total).
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [5:0]  x;
    logic [5:0]  y;
    logic        ls;
    logic        fs;
    logic        vb;
    logic [15:0] fc;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        px_ce = 1'b1;
  logic        hsync, vsync, de, line_start, frame_start, vblank_start;
  logic [5:0]  x, y;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0), .COORD_W(6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef VGA_TIMING_CE_EN
    .px_ce        (px_ce),
`endif
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .x            (x),
    .y            (y),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .vblank_start (vblank_start),
    .frame_count  (frame_count)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  int   mh = 0, mv = 0, mfc = 0, cyc = 0;
  bit   mfirst = 1'b1;
  obs_t last_e = '{hs: 1'b1, vs: 1'b1, default: '0};

  int   n_ls, n_ls_rise, n_fs, n_vb, n_vs_low, n_hs_low, last_rise, rise_gap;
  logic prev_ls;

  task automatic clear_stats();
    n_ls = 0; n_ls_rise = 0; n_fs = 0; n_vb = 0; n_vs_low = 0; n_hs_low = 0;
    last_rise = -1; rise_gap = 0; prev_ls = 1'b0;
  endtask

  task automatic check_val(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst_i, input logic ce_i, input string tag);
    obs_t e, o;
    @(negedge clk);
    reset = rst_i;
    px_ce = ce_i;
    if (rst_i) begin
      e = '0; e.hs = 1'b1; e.vs = 1'b1;
      mh = 0; mv = 0; mfc = 0; mfirst = 1'b1;
    end else if (ce_i) begin
      e.de = (mh < HA) && (mv < VA);
      e.hs = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
      e.vs = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
      e.x  = 6'(mh);
      e.y  = 6'(mv);
      e.ls = (mh == 0);
      e.fs = (mh == 0) && (mv == 0);
      e.vb = (mh == 0) && (mv == VA);
      if (e.fs) begin
        if (mfirst) mfirst = 1'b0;
        else mfc = (mfc + 1) % 65536;
      end
      e.fc = 16'(mfc);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end else begin
      e = last_e;
      e.ls = 1'b0; e.fs = 1'b0; e.vb = 1'b0;
    end
    last_e = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o = '{hs: hsync, vs: vsync, de: de, x: x, y: y, ls: line_start,
          fs: frame_start, vb: vblank_start, fc: frame_count};
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
    if (line_start) n_ls++;
    if (line_start && !prev_ls) begin
      n_ls_rise++;
      if (last_rise >= 0) rise_gap = cyc - last_rise;
      last_rise = cyc;
    end
    prev_ls = line_start;
    if (frame_start) n_fs++;
    if (vblank_start) n_vb++;
    if (!vsync) n_vs_low++;
    if (!hsync) n_hs_low++;
  endtask

  initial begin
    int guard;
    clear_stats();

    repeat (3) step(1'b1, 1'b1, "reset_hold");
    check_val("rst_hsync", int'(hsync), 1);
    check_val("rst_vsync", int'(vsync), 1);
    check_val("rst_de", int'(de), 0);
    check_val("rst_fc", int'(frame_count), 0);

    clear_stats();
    step(1'b0, 1'b1, "release");
    check_val("rel_de", int'(de), 1);
    check_val("rel_fs", int'(frame_start), 1);
    check_val("rel_x", int'(x), 0);
    check_val("rel_y", int'(y), 0);
    for (int i = 2; i <= HA; i++) step(1'b0, 1'b1, "run");
    check_val("last_active_x", int'(x), HA - 1);
    check_val("last_active_de", int'(de), 1);
    step(1'b0, 1'b1, "run");
    check_val("first_blank_de", int'(de), 0);
    for (int i = HA + 2; i <= 3 * FRAME + 1; i++) step(1'b0, 1'b1, "run");
    check_val("fc_3_frames", int'(frame_count), 3);
    check_val("wrap_fs", int'(frame_start), 1);
    check_val("wrap_xy", int'({x, y}), 0);
    check_val("n_frame_start", n_fs, 4);
    check_val("n_line_start", n_ls, 3 * VT + 1);
    check_val("line_period", rise_gap, HT);
    check_val("n_vblank", n_vb, 3);
    check_val("vsync_low_cycles", n_vs_low, 3 * VS * HT);
    check_val("hsync_low_cycles", n_hs_low, 3 * VT * HS);

    guard = 0;
    while (!(mv == 5 && mh == 10) && guard < 2 * FRAME) begin
      step(1'b0, 1'b1, "to_mid");
      guard++;
    end
    check_val("mid_reached", guard < 2 * FRAME ? 1 : 0, 1);
    step(1'b1, 1'b1, "mid_reset");
    check_val("mid_rst_de", int'(de), 0);
    check_val("mid_rst_xy", int'({x, y}), 0);
    check_val("mid_rst_hv", int'({hsync, vsync}), 3);
    step(1'b0, 1'b1, "mid_release");
    check_val("mid_rel_fs", int'(frame_start), 1);
    check_val("mid_rel_fc", int'(frame_count), 0);

`ifdef VGA_TIMING_CE_EN
    clear_stats();
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, (i % 2) == 1, "ce_toggle");
    check_val("ce_ls_one_cycle", n_ls, n_ls_rise);
    check_val("ce_n_line_start", n_ls_rise, VT);
    check_val("ce_line_period", rise_gap, 2 * HT);
    check_val("ce_n_frame_start", n_fs, 1);
    check_val("ce_fc", int'(frame_count), 1);
`else
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, "tail");
    check_val("tail_fc", int'(frame_count), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
